// File: rtl/vga_char_queue.sv
// vga_char_queue: command FIFO feeding a VGA character RAM.
// Host words are queued, then drained one at a time into character-cell
// writes (row*COLS+col) or a full-screen clear sweep of spaces.
// Optional build macro: VGA_CHARQ_BLANK_GATE_EN. When defined, draining and
// RAM writes are gated by v_blank. When undefined, v_blank is ignored.
// Ports:
//   Bus2IP_Clk, Bus2IP_Reset     clock, synchronous active-high reset
//   wr_valid, wr_data, wr_ready  host command push handshake
//   v_blank                      vertical blanking from the VGA timing stage
//   ram_we, ram_addr, ram_data   character RAM write port (registered)
//   count                        FIFO occupancy
//   range_err                    sticky: an out-of-range command was dropped
module vga_char_queue #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned COLS  = 40,
   parameter int unsigned ROWS  = 30
) (
   input  logic        Bus2IP_Clk,
   input  logic        Bus2IP_Reset,
   input  logic        wr_valid,
   input  logic [0:31] wr_data,
   output logic        wr_ready,
   input  logic        v_blank,
   output logic        ram_we,
   output logic [0:10] ram_addr,
   output logic [0:6]  ram_data,
   output logic [0:4]  count,
   output logic        range_err
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned ADDR_W = 11;
   localparam int unsigned CHAR_W = 7;
   localparam int unsigned CELLS  = ROWS * COLS;

   typedef struct packed {
      logic              clr;
      logic [4:0]        row;
      logic [5:0]        col;
      logic [CHAR_W-1:0] ch;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
   logic                ram_we_q, ram_we_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [CHAR_W-1:0]   ram_data_q, ram_data_d;
   logic                range_err_q, range_err_d;
   logic                pop_hold_q, pop_hold_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                wr_ready_q, wr_ready_d;
   cmd_t                mem_q [DEPTH];

   cmd_t                wr_cmd_c, head_c;
   logic                head_oor_c;
   logic [ADDR_W-1:0]   head_addr_c;
   logic                gate_c, push_c, pop_c;
   logic                unused_c;

   // Drain gate
`ifdef VGA_CHARQ_BLANK_GATE_EN
   assign gate_c   = v_blank;
   assign unused_c = ^wr_data[12:24];
`else
   assign gate_c   = 1'b1;
   assign unused_c = ^{wr_data[12:24], v_blank};
`endif

   // Field extraction from the host word
   assign wr_cmd_c.clr = wr_data[0];
   assign wr_cmd_c.row = wr_data[1:5];
   assign wr_cmd_c.col = wr_data[6:11];
   assign wr_cmd_c.ch  = wr_data[25:31];

   // Head entry decode
   assign head_c      = mem_q[rd_ptr_q];
   assign head_oor_c  = (32'(head_c.row) >= ROWS) || (32'(head_c.col) >= COLS);
   assign head_addr_c = ADDR_W'(32'(head_c.row) * COLS + 32'(head_c.col));

   // Push is decided on the registered (pre-edge) not-full flag only
   assign push_c = wr_valid && wr_ready_q;

   // FSM next state and registered outputs
   always_comb begin
      state_d     = state_q;
      clr_addr_d  = clr_addr_q;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_data_d  = ram_data_q;
      range_err_d = range_err_q;
      pop_c       = 1'b0;
      pop_hold_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            // pop_hold keeps back-to-back dropped entries to one pop per 2 cycles
            if ((count_q != '0) && gate_c && !pop_hold_q) begin
               pop_c      = 1'b1;
               pop_hold_d = 1'b1;
               if (head_c.clr) begin
                  state_d    = CLEAR;
                  clr_addr_d = '0;
               end else if (head_oor_c) begin
                  range_err_d = 1'b1;
               end else begin
                  state_d    = WRITE;
                  ram_we_d   = 1'b1;
                  ram_addr_d = head_addr_c;
                  ram_data_d = head_c.ch;
               end
            end
         end
         WRITE: begin
            // strobe is already on the outputs this cycle
            state_d = IDLE;
         end
         CLEAR: begin
            if (gate_c) begin
               ram_we_d   = 1'b1;
               ram_addr_d = clr_addr_q;
               ram_data_d = CHAR_W'(7'h20);
               if (clr_addr_q == ADDR_W'(CELLS - 1)) begin
                  state_d = IDLE;
               end else begin
                  clr_addr_d = clr_addr_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FIFO pointers and occupancy
   always_comb begin
      wr_ptr_d   = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      wr_ready_d = (count_d != CNT_W'(DEPTH));
   end

   // State and control registers
   always_ff @(posedge Bus2IP_Clk) begin
      if (Bus2IP_Reset) begin
         state_q     <= IDLE;
         clr_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_data_q  <= '0;
         range_err_q <= 1'b0;
         pop_hold_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         wr_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         clr_addr_q  <= clr_addr_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_data_q  <= ram_data_d;
         range_err_q <= range_err_d;
         pop_hold_q  <= pop_hold_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         wr_ready_q  <= wr_ready_d;
      end
   end

   // FIFO storage (no reset needed; validity tracked by pointers)
   always_ff @(posedge Bus2IP_Clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= wr_cmd_c;
      end
   end

   assign wr_ready  = wr_ready_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_data  = ram_data_q;
   assign count     = 5'(count_q);
   assign range_err = range_err_q;

endmodule

// File: tb/tb_vga_char_queue.sv
// Self-checking bench for vga_char_queue: a reference model turns every
// accepted command into the RAM strobes it must produce; a monitor compares
// each observed strobe against that expectation queue.
module tb_vga_char_queue;

   localparam int DEPTH = 16;
   localparam int COLS  = 40;
   localparam int ROWS  = 30;
   localparam int CELLS = ROWS * COLS;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_valid = 1'b0;
   logic [0:31] wr_data = '0;
   logic        wr_ready;
   logic        v_blank = 1'b1;
   logic        ram_we;
   logic [0:10] ram_addr;
   logic [0:6]  ram_data;
   logic [0:4]  count;
   logic        range_err;

   typedef struct {
      int addr;
      int data;
   } strobe_t;

   strobe_t exp_q[$];
   bit      exp_range = 1'b0;
   bit      vb_s = 1'b0;
   int      n_chk = 0;
   int      n_pass = 0;

   vga_char_queue #(.DEPTH(DEPTH), .COLS(COLS), .ROWS(ROWS)) dut (
      .Bus2IP_Clk  (clk),
      .Bus2IP_Reset(rst),
      .wr_valid    (wr_valid),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .v_blank     (v_blank),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_data    (ram_data),
      .count       (count),
      .range_err   (range_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic logic [0:31] mk_cmd(input bit clr, input int row, input int col, input int ch);
      logic [0:31] w;
      w        = '0;
      w[12:24] = 13'($urandom);
      w[0]     = clr;
      w[1:5]   = 5'(row);
      w[6:11]  = 6'(col);
      w[25:31] = 7'(ch);
      return w;
   endfunction

   // Reference model: strobes an accepted command must eventually produce
   task automatic model_push(input bit clr, input int row, input int col, input int ch);
      strobe_t s;
      if (clr) begin
         for (int a = 0; a < CELLS; a++) begin
            s.addr = a; s.data = 'h20; exp_q.push_back(s);
         end
      end else if (row >= ROWS || col >= COLS) begin
         exp_range = 1'b1;
      end else begin
         s.addr = row * COLS + col; s.data = ch; exp_q.push_back(s);
      end
   endtask

   // Push one command using the valid/ready handshake
   task automatic send(input bit clr, input int row, input int col, input int ch);
      int t = 0;
      wr_data  = mk_cmd(clr, row, col, ch);
      wr_valid = 1'b1;
      while (!wr_ready && t < 3000) begin
         @(posedge clk); #1; t++;
      end
      if (!wr_ready) begin
         chk("send_timeout", 32'(wr_ready), 32'd1);
      end else begin
         model_push(clr, row, col, ch);
         @(posedge clk); #1;
      end
      wr_valid = 1'b0;
   endtask

   task automatic wait_drain(input int bound);
      int t = 0;
      while ((exp_q.size() != 0 || count != 0 || ram_we) && t < bound) begin
         @(posedge clk); #1; t++;
      end
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
      chk("drain_count", 32'(count), 32'd0);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(posedge clk) vb_s <= v_blank;

   // Monitor: every strobe must match the head of the expectation queue
   always @(negedge clk) begin
      if (!rst && ram_we) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_strobe: addr %0d data %0h, expected no strobe", ram_addr, ram_data);
         end else begin
            strobe_t e;
            e = exp_q.pop_front();
            chk("strobe_addr", 32'(ram_addr), 32'(e.addr));
            chk("strobe_data", 32'(ram_data), 32'(e.data));
         end
`ifdef VGA_CHARQ_BLANK_GATE_EN
         if (!vb_s) begin
            n_chk++;
            $display("FAIL strobe_outside_blank: ram_we 1, expected 0 (addr %0d)", ram_addr);
         end
`endif
      end
   end

   initial begin
      int t;
      // Reset state
      cycles(3);
      @(negedge clk);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd1);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_ram_data", 32'(ram_data), 32'd0);
      chk("rst_range_err", 32'(range_err), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Single character write, row 2 col 3 -> addr 83
`ifdef VGA_CHARQ_BLANK_GATE_EN
      v_blank = 1'b0;
      send(1'b0, 2, 3, 'h41);
      cycles(4);
      chk("gated_count", 32'(count), 32'd1);
      chk("gated_no_we", 32'(ram_we), 32'd0);
      v_blank = 1'b1;
`else
      send(1'b0, 2, 3, 'h41);
`endif
      wait_drain(50);

      // Out-of-range entries are dropped; next valid entry still written
      send(1'b0, 30, 0, 'h11);
      send(1'b0, 29, 39, 'h5a);
      send(1'b0, 0, 40, 'h12);
      send(1'b0, 0, 0, 'h7f);
      wait_drain(50);
      chk("range_err_set", 32'(range_err), 32'(exp_range));

      // Randomized command stream
      for (int i = 0; i < 60; i++) begin
         int row, col;
         if ($urandom_range(0, 4) == 0) begin
            row = $urandom_range(0, 31); col = $urandom_range(0, 63);
         end else begin
            row = $urandom_range(0, ROWS - 1); col = $urandom_range(0, COLS - 1);
         end
         send(1'b0, row, col, $urandom_range(0, 127));
         cycles($urandom_range(0, 3));
      end
      wait_drain(200);
      chk("range_err_sticky", 32'(range_err), 32'(exp_range));

      // Fill the FIFO behind a running clear: 16 accepted, 17th dropped
      send(1'b1, 0, 0, 0);
      cycles(3);
      for (int i = 0; i < 17; i++) begin
         int row, col, ch;
         row = $urandom_range(0, ROWS - 1); col = $urandom_range(0, COLS - 1);
         ch = $urandom_range(0, 127);
         wr_data  = mk_cmd(1'b0, row, col, ch);
         wr_valid = 1'b1;
         if (i < DEPTH) model_push(1'b0, row, col, ch);
         @(posedge clk); #1;
         if (i == DEPTH - 1) begin
            chk("full_wr_ready", 32'(wr_ready), 32'd0);
            chk("full_count", 32'(count), 32'd16);
         end
      end
      wr_valid = 1'b0;
      chk("drop_count", 32'(count), 32'd16);
      chk("drop_wr_ready", 32'(wr_ready), 32'd0);

      // Pause the clear sweep around address 500
      t = 0;
      do begin
         @(negedge clk); t++;
      end while (!(ram_we && ram_addr == 11'd500) && t < 2000);
      chk("reach_addr_500", 32'(ram_addr), 32'd500);
      v_blank = 1'b0;
      cycles(10);
      v_blank = 1'b1;
      wait_drain(3000);

      // Reset mid-clear with 5 entries queued
      send(1'b1, 0, 0, 0);
      cycles(20);
      for (int i = 0; i < 5; i++) send(1'b0, i, i, 'h30 + i);
      cycles(100);
      chk("pre_rst_count", 32'(count), 32'd5);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_ram_we", 32'(ram_we), 32'd0);
      chk("midrst_wr_ready", 32'(wr_ready), 32'd1);
      chk("midrst_range_err", 32'(range_err), 32'd0);
      exp_q.delete();
      exp_range = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      cycles(40);
      chk("post_rst_count", 32'(count), 32'd0);

      // Recovery after reset
      send(1'b0, 29, 0, 'h23);
      wait_drain(50);
      chk("final_range_err", 32'(range_err), 32'(exp_range));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
